// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the exec/decode side and the phase sequencer.
// The bench/controller side uses master; the sequencer itself uses slave.
interface phase_sequencer_if;
  logic        exec_n;
  logic        halt_req;
  logic [2:0]  phase;
  logic        running;
  logic        halt;
  logic [15:0] instr_count;

  modport master (
    output exec_n,
    output halt_req,
    input  phase,
    input  running,
    input  halt,
    input  instr_count
  );

  modport slave (
    input  exec_n,
    input  halt_req,
    output phase,
    output running,
    output halt,
    output instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// Debounced exec pushbutton driving a five-phase instruction sequencer (IDLE/RUN/HALTED).
// Optional single-step input port step_mode is added when PHASE_SEQUENCER_STEP_MODE_EN is defined.
module phase_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
  input  logic step_mode,
`endif
  phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LAST_PHASE = 3'd4;
  localparam logic [2:0] HALT_PHASE = 3'd2;

  logic        sync_p0;
  logic        sync_p1;
  logic        level;
  logic [7:0]  db_cnt;
  logic        press;
  logic        step_sel;

  state_t      state;
  logic [2:0]  phase_q;
  logic        running_q;
  logic        halt_q;
  logic [15:0] count_q;
  logic        stop_pending;
  logic        halt_pending;
  logic        step_once;

  // Phase advance; anything outside 0..3 folds back to 0 so 5..7 can never appear.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    if (p >= LAST_PHASE) begin
      return 3'd0;
    end
    return 3'(p + 3'd1);
  endfunction

`ifdef PHASE_SEQUENCER_STEP_MODE_EN
  assign step_sel = step_mode;
`else
  assign step_sel = 1'b0;
`endif

  // Stage p0/p1: two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.exec_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: count consecutive clocks the synchronized level differs from the accepted one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level  <= 1'b1;
      db_cnt <= 8'd0;
    end else if (sync_p1 == level) begin
      db_cnt <= 8'd0;
    end else if (db_cnt == DB_LAST) begin
      level  <= sync_p1;
      db_cnt <= 8'd0;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // Press fires on the same clock the accepted level falls from 1 to 0.
  assign press = level & ~sync_p1 & (db_cnt == DB_LAST);

  // Sequencer: a stop or halt request only takes effect at the 4->0 wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phase_q      <= 3'd0;
      running_q    <= 1'b0;
      halt_q       <= 1'b0;
      count_q      <= 16'd0;
      stop_pending <= 1'b0;
      halt_pending <= 1'b0;
      step_once    <= 1'b0;
    end else begin
      halt_q <= 1'b0;
      unique case (state)
        IDLE, HALTED: begin
          phase_q <= 3'd0;
          if (press) begin
            state     <= RUN;
            running_q <= 1'b1;
            step_once <= (state == IDLE) & step_sel;
          end
        end
        RUN: begin
          if (phase_q == LAST_PHASE) begin
            phase_q      <= 3'd0;
            count_q      <= count_q + 16'd1;
            halt_pending <= 1'b0;
            step_once    <= 1'b0;
            stop_pending <= 1'b0;
            if (halt_pending) begin
              state     <= HALTED;
              running_q <= 1'b0;
              halt_q    <= 1'b1;
            end else if (stop_pending | step_once) begin
              state     <= IDLE;
              running_q <= 1'b0;
            end else begin
              // A press landing on the wrap belongs to the instruction that starts now.
              stop_pending <= press;
            end
          end else begin
            phase_q <= next_phase(phase_q);
            if (press) begin
              stop_pending <= 1'b1;
            end
            if ((phase_q == HALT_PHASE) && bus.halt_req) begin
              halt_pending <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          phase_q   <= 3'd0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase       = phase_q;
  assign bus.running     = running_q;
  assign bus.halt        = halt_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes model predictions, a monitor pops and compares.
module tb_phase_sequencer;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
  logic step_mode = 1'b0;
  bit   rand_phase = 1'b0;
`endif

  phase_sequencer_if bus ();

  phase_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
    .step_mode (step_mode),
`endif
    .bus       (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  phase;
    logic        running;
    logic        halt;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: button history windows plus an abstract instruction slot counter.
  bit          sq[$]  = '{1'b1, 1'b1};
  bit          win[$];
  bit          m_level  = 1'b1;
  int          m_mode   = 0;   // 0 idle, 1 run, 2 halted
  int          m_ph     = 0;
  bit          m_stop   = 1'b0;
  bit          m_hpend  = 1'b0;
  bit          m_single = 1'b0;
  bit          m_halt   = 1'b0;
  logic [15:0] m_count  = 16'd0;

  task automatic model_step(input bit r, input bit ex, input bit hr, input bit sm);
    bit s;
    bit press;
    bit all_new;
    exp_t e;
    if (r) begin
      sq = '{1'b1, 1'b1};
      win.delete();
      m_level = 1'b1; m_mode = 0; m_ph = 0;
      m_stop = 1'b0; m_hpend = 1'b0; m_single = 1'b0; m_halt = 1'b0;
      m_count = 16'd0;
    end else begin
      s = sq.pop_front();
      sq.push_back(ex);
      win.push_back(s);
      if (win.size() > N) void'(win.pop_front());
      press = 1'b0;
      if (win.size() == N) begin
        all_new = 1'b1;
        foreach (win[i]) if (win[i] == m_level) all_new = 1'b0;
        if (all_new) begin
          m_level = !m_level;
          press   = (m_level == 1'b0);
        end
      end
      m_halt = 1'b0;
      if (m_mode == 1) begin
        if (m_ph == 4) begin
          m_count = m_count + 16'd1;
          if (m_hpend) begin
            m_mode = 2;
            m_halt = 1'b1;
          end else if (m_stop || m_single) begin
            m_mode = 0;
          end
          m_stop   = (m_mode == 1) && press;
          m_hpend  = 1'b0;
          m_single = 1'b0;
          m_ph     = 0;
        end else begin
          if (press) m_stop = 1'b1;
          if (m_ph == 2 && hr) m_hpend = 1'b1;
          m_ph = (m_ph + 1) % 5;
        end
      end else if (press) begin
        m_single = (m_mode == 0) && sm;
        m_mode   = 1;
        m_ph     = 0;
      end
    end
    e.phase   = 3'(m_ph);
    e.running = (m_mode == 1);
    e.halt    = m_halt;
    e.count   = m_count;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the outputs after the coming rising edge.
  task automatic cycle(input bit r, input bit ex, input bit hr);
    bit sm;
    sm = 1'b0;
    @(negedge clock);
    reset        = r;
    bus.exec_n   = ex;
    bus.halt_req = hr;
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
    step_mode = rand_phase ? ($urandom_range(0, 3) == 0) : 1'b0;
    sm        = step_mode;
`endif
    model_step(r, ex, hr, sm);
  endtask

  // Button press of low_len clocks then release; optional halt request at phase 2 once a stop is pending.
  task automatic press_btn(input int low_len, input int high_len, input bit with_halt);
    for (int i = 0; i < low_len; i++)
      cycle(1'b0, 1'b0, with_halt && m_mode == 1 && m_ph == 2 && m_stop);
    for (int i = 0; i < high_len; i++)
      cycle(1'b0, 1'b1, with_halt && m_mode == 1 && m_ph == 2 && m_stop);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 40 && !(m_mode == 1 && m_ph == ph); i++) cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("phase",       16'(bus.phase),   16'(e.phase));
        check("running",     16'(bus.running), 16'(e.running));
        check("halt",        16'(bus.halt),    16'(e.halt));
        check("instr_count", bus.instr_count,  e.count);
      end
    end
  end

  initial begin : driver
    int hold;
    bit lvl;
    bus.exec_n   = 1'b1;
    bus.halt_req = 1'b0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);

    // Short glitch must be rejected.
    press_btn(2, 12, 1'b0);

    // Held press starts the run within sync + debounce + FSM latency.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    check("running_by_8", 16'(bus.running), 16'd1);
    press_btn(2, N + 6, 1'b0);

    // Stop request landing at phase 1 finishes the instruction.
    wait_phase(1);
    press_btn(8, 14, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);

    // Halt plus stop in one instruction: halt wins, then a press resumes.
    press_btn(8, 8, 1'b0);
    wait_phase(1);
    press_btn(8, 14, 1'b1);
    press_btn(8, 8, 1'b0);
    press_btn(8, 14, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);

    // Counter wrap from 16'hFFFF.
    for (int i = 0; i < 40 && m_mode != 0; i++) cycle(1'b0, 1'b1, 1'b0);
    @(posedge clock);
    #2;
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    release dut.count_q;
    cycle(1'b0, 1'b1, 1'b0);
    press_btn(8, 8, 1'b0);
    press_btn(8, 14, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);

    // Reset in the middle of the first instruction.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !(m_mode == 1 && m_ph == 3); i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("rst_phase",   16'(bus.phase),   16'd0);
    check("rst_running", 16'(bus.running), 16'd0);
    check("rst_count",   bus.instr_count,  16'd0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);

    // Random button, halt requests and rare resets.
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
    rand_phase = 1'b1;
`endif
    lvl = 1'b1;
    for (int i = 0; i < 900; i += hold) begin
      hold = $urandom_range(1, 9);
      lvl  = ($urandom_range(0, 2) == 0) ? lvl : !lvl;
      for (int k = 0; k < hold; k++)
        cycle($urandom_range(0, 299) == 0, lvl, $urandom_range(0, 2) == 0);
    end
`ifdef PHASE_SEQUENCER_STEP_MODE_EN
    rand_phase = 1'b0;
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);

    @(posedge clock);
    #3;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
